// File: rtl/ram_arb_pkg.sv
// Shared types and slot constants for the system RAM arbiter.
// Optional build macro: RAM_ARB_DMA_HOLD_EN (DMA hold of the CPU cadence).
package ram_arb_pkg;

  localparam int CPU_DIV_DEF = 25;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } dma_st_e;

  function automatic logic [CNT_W-1:0] slot_setup(input int div);
    return CNT_W'(div - 2);
  endfunction

  function automatic logic [CNT_W-1:0] slot_access(input int div);
    return CNT_W'(div - 1);
  endfunction

  function automatic logic [CNT_W-1:0] slot_dma_last(input int div);
    return CNT_W'(div - 3);
  endfunction

endpackage

// File: rtl/cpu_slot_timer.sv
// CPU period counter, clock-enable decode and DMA issue window.
// With RAM_ARB_DMA_HOLD_EN the count parks on the last DMA slot.
module cpu_slot_timer
  import ram_arb_pkg::*;
#(
  parameter int DIV = CPU_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  output logic clken_o,
  output logic access_o,
  output logic dma_ok_o
);

  localparam logic [CNT_W-1:0] ACC  = slot_access(DIV);
  localparam logic [CNT_W-1:0] LAST = slot_dma_last(DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat;

`ifdef RAM_ARB_DMA_HOLD_EN
  assign sat = hold_i && (cnt_q == LAST);
`else
  logic unused_hold;
  assign unused_hold = hold_i;
  assign sat = 1'b0;
`endif

  // Next count: wrap at the access slot, park while held
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == ACC) cnt_d = '0;
    if (sat) cnt_d = cnt_q;
  end

  // Slot counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign access_o = (cnt_q == ACC);
  assign clken_o  = access_o & ~rst_i;
  assign dma_ok_o = (cnt_q <= LAST);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the system RAM between the 6502 slots and a DMA port.
// Optional build macro: RAM_ARB_DMA_HOLD_EN (dma_hold suspends CPU slots).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int CPU_DIV = CPU_DIV_DEF,
  parameter int ADDR_W  = 13
) (
  input  logic              clk25,
  input  logic              rst,
  output logic              cpu_clken,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  input  logic              dma_hold,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  dma_st_e    st_q, st_d;
  logic [7:0] rdata_q, rdata_d;
  logic       acc_slot;
  logic       dma_ok;
  logic       issue;

  cpu_slot_timer #(
    .DIV (CPU_DIV)
  ) u_timer (
    .clk_i    (clk25),
    .rst_i    (rst),
    .hold_i   (dma_hold),
    .clken_o  (cpu_clken),
    .access_o (acc_slot),
    .dma_ok_o (dma_ok)
  );

  // DMA FSM: issue in a free slot, capture read data, pulse ack
  always_comb begin
    st_d    = st_q;
    rdata_d = rdata_q;
    issue   = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (dma_req && dma_ok) begin
          issue = 1'b1;
          st_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rdata_d = ram_dout;
        st_d    = ST_ACK;
      end
      ST_ACK:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // DMA state and read-data registers
  always_ff @(posedge clk25) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM port mux: DMA in its issue cycle, CPU otherwise
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    ram_we   = 1'b0;
    if (issue) begin
      ram_addr = dma_addr;
      ram_din  = dma_wdata;
      ram_we   = dma_we;
    end else if (acc_slot) begin
      ram_we = cpu_we & cpu_cs;
    end
    if (rst) ram_we = 1'b0;
  end

  assign dma_ack   = (st_q == ST_ACK) & ~rst;
  assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM.
// Hold scenario is exercised when RAM_ARB_DMA_HOLD_EN is defined.
module tb_ram_arbiter;

  localparam int DIV = 25;
  localparam int AW  = 13;

  logic          clk25 = 1'b0;
  logic          rst;
  logic          cpu_clken;
  logic [AW-1:0] cpu_addr;
  logic          cpu_cs, cpu_we;
  logic [7:0]    cpu_wdata;
  logic          dma_req, dma_we, dma_hold;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  ram_arbiter #(.CPU_DIV(DIV), .ADDR_W(AW)) dut (
    .clk25(clk25), .rst(rst), .cpu_clken(cpu_clken),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_hold(dma_hold),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk25 = ~clk25;

  logic [7:0] mem    [0:8191];
  logic [7:0] shadow [0:8191];

  always @(posedge clk25) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk25) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int ph();
    return cyc % DIV;
  endfunction

  function automatic int exp_lat(input int p);
    return ((p <= DIV - 3) ? 0 : (DIV - p)) + 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  bit         mon_en = 0;
  bit         cpu_chk = 0;
  bit         rnd_cpu = 0;
  bit         hold_watch = 0;
  int         hold_clk = 0;
  int         we_cnt = 0;
  int         we_ph = -1;
  int         rd_seq = 0;
  int         rd_done = 0;
  logic [7:0] rd_seen;
  logic [12:0] rd_a;

  always @(negedge clk25) begin
    if (mon_en && !rst) begin
      chk("clken_cadence", cpu_clken, (ph() == DIV - 1));
      if (ph() >= DIV - 2) chk("cpu_slot_addr", ram_addr, cpu_addr);
      if (ph() == DIV - 2) chk("setup_no_we", ram_we, 0);
    end
    if (cpu_chk && !rst && cpu_clken) begin
      rd_seen = ram_dout;
      rd_a    = cpu_addr;
      rd_seq++;
    end
    if (hold_watch && cpu_clken) hold_clk++;
    if (ram_we) begin
      we_cnt++;
      we_ph = ph();
    end
  end

  // Advance one cycle; apply the CPU-write rule to the model first
  task automatic tick();
    @(posedge clk25);
    if (rd_seq != rd_done) begin
      rd_done = rd_seq;
      chk("cpu_read", rd_seen, shadow[rd_a]);
    end
    if (!rst && (cyc % DIV) == DIV - 1 && cpu_cs && cpu_we)
      shadow[cpu_addr] = cpu_wdata;
    #1;
    if (rnd_cpu && (cyc % DIV) == 0) begin
      cpu_addr  = 13'h300 + 13'($urandom_range(0, 7));
      cpu_cs    = 1'($urandom);
      cpu_we    = 1'($urandom);
      cpu_wdata = 8'($urandom);
`ifndef RAM_ARB_DMA_HOLD_EN
      dma_hold  = 1'($urandom);
`endif
    end
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i <= DIV; i++) begin
      if (ph() == p) break;
      tick();
    end
  endtask

  task automatic dma_op(input logic we, input logic [12:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output logic [7:0] mdl, output int lat);
    bit got;
    got = 0;
    dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    lat = 0; rd = '0; mdl = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk25);
      if (dma_ack) begin
        got = 1;
        rd  = dma_rdata;
        mdl = shadow[a];
        if (we) shadow[a] = d;
      end else begin
        tick();
        lat++;
      end
    end
    if (!got) chk("dma_ack_timeout", 0, 1);
    tick();
    dma_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    int          phase;
    logic [7:0]  exp_rd;
    bit          chk_rd;
    int          exp_lat;
    int          exp_we_ph;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] rd, mdl;
    int lat, p, c0, wr_cyc, ic, bad, prev;
    int pulses[$];

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, mdl;
    int lat, p, c0, wr_cyc, ic, bad, prev;
    int pulses[$];

    tbl[0] = '{1'b1, 13'h0123, 8'h5A, 3,  8'h00, 0, 2, 3};
    tbl[1] = '{1'b0, 13'h0123, 8'h00, 3,  8'h5A, 1, 2, -1};
    tbl[2] = '{1'b1, 13'h1FFF, 8'hC3, 22, 8'h00, 0, 2, 22};
    tbl[3] = '{1'b0, 13'h1FFF, 8'h00, 23, 8'hC3, 1, 4, -1};
    tbl[4] = '{1'b0, 13'h0123, 8'h00, 24, 8'h5A, 1, 3, -1};
    tbl[5] = '{1'b1, 13'h0000, 8'h11, 0,  8'h00, 0, 2, 0};
    tbl[6] = '{1'b0, 13'h0000, 8'h00, 10, 8'h11, 1, 2, -1};
    tbl[7] = '{1'b0, 13'h0040, 8'h00, 7,  8'h00, 1, 2, -1};

    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    rst = 1'b1; cpu_addr = 13'h0100; cpu_cs = 1'b0; cpu_we = 1'b0;
    cpu_wdata = 8'h00; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0;
    dma_wdata = 8'h00; dma_hold = 1'b0;
    repeat (3) tick();

    @(negedge clk25);
    chk("rst_clken", cpu_clken, 0);
    chk("rst_ack", dma_ack, 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, cpu_addr);
    tick();
    rst = 1'b0;
    mon_en = 1;

    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk25);
      if (cpu_clken) pulses.push_back(cyc);
      if (dma_ack || dma_rdata != 8'h00) bad = 1;
      tick();
    end
    chk("clken_pulse_count", pulses.size(), 3);
    for (int i = 0; i < pulses.size() && i < 3; i++)
      chk("clken_pulse_cycle", pulses[i], 24 + 25 * i);
    chk("idle_ack_rdata_zero", bad, 0);

    for (int i = 0; i < 8; i++) begin
      goto_phase(tbl[i].phase);
      we_cnt = 0;
      dma_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, mdl, lat);
      chk("tbl_lat", lat, tbl[i].exp_lat);
      if (tbl[i].chk_rd) chk("tbl_rdata", rd, tbl[i].exp_rd);
      if (tbl[i].we) begin
        chk("tbl_we_count", we_cnt, 1);
        chk("tbl_we_phase", we_ph, tbl[i].exp_we_ph);
      end else begin
        chk("tbl_read_no_we", we_cnt, 0);
      end
    end

    goto_phase(DIV - 2);
    cpu_addr = 13'h0123; cpu_cs = 1'b1; cpu_we = 1'b0;
    dma_we = 1'b0; dma_addr = 13'h1FFF; dma_req = 1'b1;
    @(negedge clk25);
    chk("late_req_setup_addr", ram_addr, 13'h0123);
    tick();
    @(negedge clk25);
    chk("late_req_access_addr", ram_addr, 13'h0123);
    chk("cpu_read_clken", ram_dout, 8'h5A);
    chk("late_req_access_we", ram_we, 0);
    tick();
    @(negedge clk25);
    chk("late_req_issue_cnt0", ram_addr, 13'h1FFF);
    tick();
    tick();
    @(negedge clk25);
    chk("late_req_ack", dma_ack, 1);
    chk("late_req_rdata", dma_rdata, 8'hC3);
    tick();
    dma_req = 1'b0; cpu_cs = 1'b0;

    goto_phase(0);
    cpu_addr = 13'h0040; cpu_wdata = 8'hA5; cpu_we = 1'b1; cpu_cs = 1'b1;
    wr_cyc = cyc + DIV - 1;
    for (int k = 0; k < 10; k++) begin
      c0 = cyc;
      p  = ph();
      dma_op(1'b0, 13'h0040, 8'h00, rd, mdl, lat);
      ic = c0 + exp_lat(p) - 2;
      chk("stream_lat", lat, exp_lat(p));
      chk("stream_rdata", rd, (ic > wr_cyc) ? 8'hA5 : 8'h00);
    end
    cpu_we = 1'b0; cpu_cs = 1'b0;

    goto_phase(5);
    dma_we = 1'b1; dma_addr = 13'h0200; dma_wdata = 8'hEE; dma_req = 1'b1;
    rst = 1'b1;
    @(negedge clk25);
    chk("rst_issue_we", ram_we, 0);
    tick();
    rst = 1'b0; dma_req = 1'b0;
    @(negedge clk25);
    chk("post_rst_rdata", dma_rdata, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk25);
      if (dma_ack) bad = 1;
      tick();
    end
    chk("post_rst_no_ack", bad, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk25);
      if (cpu_clken) break;
      tick();
    end
    chk("first_clken_after_rst", cyc, 24);
    tick();
    dma_op(1'b0, 13'h0200, 8'h00, rd, mdl, lat);
    chk("dropped_write_rdata", rd, 8'h00);
    chk("post_rst_idle_lat", lat, exp_lat(1));

    goto_phase(0);
    rnd_cpu = 1;
    cpu_chk = 1;
    for (int k = 0; k < 60; k++) begin
      logic        w;
      logic [12:0] a;
      logic [7:0]  d;
      repeat ($urandom_range(0, 4)) tick();
      w = 1'($urandom);
      a = 13'h300 + 13'($urandom_range(0, 7));
      d = 8'($urandom);
      p = ph();
      dma_op(w, a, d, rd, mdl, lat);
      chk("rnd_lat", lat, exp_lat(p));
      if (!w) chk("rnd_rdata", rd, mdl);
    end
    rnd_cpu = 0;
    goto_phase(1);
    cpu_chk = 0; cpu_cs = 1'b0; cpu_we = 1'b0; dma_hold = 1'b0;

`ifdef RAM_ARB_DMA_HOLD_EN
    mon_en = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0; dma_hold = 1'b1; hold_watch = 1;
    repeat (25) tick();
    prev = -1;
    for (int k = 0; k < 33; k++) begin
      c0 = cyc;
      if (prev >= 0) chk("hold_spacing", c0 - prev, 3);
      prev = c0;
      dma_op(1'b0, 13'h0123, 8'h00, rd, mdl, lat);
      chk("hold_lat", lat, 2);
      chk("hold_rdata", rd, mdl);
    end
    hold_watch = 0;
    chk("hold_no_clken", hold_clk, 0);
    dma_hold = 1'b0;
    @(negedge clk25);
    chk("release_c0", cpu_clken, 0);
    tick();
    @(negedge clk25);
    chk("release_c1", cpu_clken, 0);
    tick();
    @(negedge clk25);
    chk("release_c2_clken", cpu_clken, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Slot scheduler and arbiter for the 8 KB system RAM at 0x0000–0x1FFF, shared between the 6502 and a secondary byte-wide requester (serial loader / DMA). It owns the CPU clock-enable cadence, reserving the last two cycles of every CPU period for the CPU and granting the remaining cycles to the DMA port through a req/ack handshake. It sits between the CPU address/data bus, the synchronous single-port RAM (1-cycle read latency) and the DMA master.

## Interface
- CPU_DIV, 25, clk25 cycles per CPU cycle; legal range 4..255
- ADDR_W, 13, RAM address width
- clk25  in  1  master clock
- rst  in  1  reset; synchronous, active-high
- cpu_clken  out  1  one-cycle CPU enable pulse, once per CPU_DIV cycles
- cpu_addr  in  ADDR_W  CPU address (ab[12:0])
- cpu_cs  in  1  CPU RAM chip select
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- dma_req  in  1  DMA request; level, held until dma_ack
- dma_we  in  1  1 = write, 0 = read; stable while dma_req
- dma_addr  in  ADDR_W  DMA address; stable while dma_req
- dma_wdata  in  8  DMA write data; stable while dma_req
- dma_hold  in  1  request to suspend CPU slots (effective only with the macro)
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  8  read data, valid while dma_ack is high
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  8  RAM write data
- ram_dout  in  8  RAM read data (registered in the RAM, 1-cycle latency)

## Operation
- Slot counter cnt: resets to 0, increments every cycle, wraps DIV-1 → 0. cpu_clken = (cnt == DIV-1), decoded from the registered counter.
- CPU setup slot (cnt == DIV-2): ram_addr = cpu_addr, ram_we = 0, so read data is valid during the clken cycle.
- CPU access slot (cnt == DIV-1): ram_addr = cpu_addr, ram_din = cpu_wdata, ram_we = cpu_we & cpu_cs.
- DMA FSM states: IDLE, WAIT, ACK.
  - IDLE: if dma_req and cnt ≤ DIV-3, issue. In the issue cycle drive ram_addr = dma_addr, ram_din = dma_wdata, ram_we = dma_we. Next state is WAIT.
  - WAIT: capture ram_dout into dma_rdata and set dma_ack. Next state is ACK.
  - ACK: dma_ack = 1. Next state is IDLE.
  - No new issue is possible during WAIT or ACK. Peak throughput is one access per 3 cycles.
- Outside the issue and CPU slots, ram_addr = cpu_addr and ram_we = 0.
- dma_rdata holds its value until the next capture. On writes it carries the old RAM contents and is don't-care for the requester.
- A request arriving at cnt ≥ DIV-2 waits for cnt = 0. A DMA access never overlaps a CPU slot.
- Reset asserted at any point: cnt = 0, FSM = IDLE, any in-flight access is dropped with no ack, and ram_we is forced to 0 in that cycle.

## Timing
- Reset values: cpu_clken 0, dma_ack 0, dma_rdata 0x00, ram_we 0, ram_addr = cpu_addr.
- First cpu_clken pulse occurs in cycle DIV-1 after reset deasserts. Pulses then repeat every DIV cycles.
- DMA latency: dma_ack is high 2 cycles after the issue cycle. Worst case from dma_req to issue is 2 cycles (waiting out the CPU slots).
- The requester may change inputs or drop dma_req in the cycle after dma_ack. If dma_req is still high in that cycle, it is treated as a new request.

## Configuration
- RAM_ARB_DMA_HOLD_EN defined: while dma_hold = 1, cnt saturates at DIV-3 (it advances up to DIV-3 and stays there). No CPU slots and no cpu_clken pulses occur, and DMA may issue every 3 cycles. When dma_hold drops, counting resumes from DIV-3 and the next CPU slot follows normally.
- RAM_ARB_DMA_HOLD_EN undefined: dma_hold is ignored and the CPU cadence is unconditional.

## Structure
- Package ram_arb_pkg contains the FSM state enum (IDLE/WAIT/ACK), the CPU_DIV default, and the slot-boundary constants (setup = DIV-2, access = DIV-1, last DMA issue slot = DIV-3).
- One sub-module, cpu_slot_timer, holds the counter, the cpu_clken decode, the slot flags and the hold saturation. The arbiter FSM and RAM muxes live in ram_arbiter.

## Test plan
- Reset release with DIV=25: cpu_clken pulses at cycles 24, 49, 74. dma_ack and dma_rdata stay 0 until a request.
- DMA write 0x5A to 0x0123 at cnt=3, then DMA read of 0x0123: ram_we high for exactly 1 cycle at cnt=3. The read's dma_ack arrives 2 cycles after its issue with dma_rdata = 0x5A.
- dma_req raised at cnt=DIV-2: no issue until cnt=0. ram_addr equals cpu_addr during both CPU slots, and the CPU reads the correct data in the clken cycle.
- CPU write 0xA5 to 0x0040 while DMA streams back-to-back reads of 0x0040: the CPU write lands only at cnt=DIV-1. Reads before that return the old value; reads after return 0xA5.
- Reset asserted in a DMA issue cycle: ram_we = 0 in that cycle, no dma_ack, FSM in IDLE, and cnt = 0 on the next cycle.
- With RAM_ARB_DMA_HOLD_EN, dma_hold high for 100 cycles: no cpu_clken pulses, cnt stays at DIV-3, and DMA ack spacing is 3 cycles. After release, the first cpu_clken comes 2 cycles later.
